prog_loader: RTL and testbench

//   Writer side of the SAP program-RAM interface. Accepts a byte stream from a

---
 rtl/prog_loader.sv | 145 ++++++++++++++
 tb/tb_prog_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - program-RAM loader: host byte stream into RAM, then CPU hold/release
// Optional trailing checksum byte: define PROG_LOADER_CHECKSUM_EN
module prog_loader #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 8,
   parameter int HOLD_CYCLES = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_we,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CHECK,
      S_RELEASE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] cnt;
   logic [HW-1:0]     hcnt;
   logic              wr_acc;
   logic              last_acc;
   logic              hold_end;
   logic              start_load;

   // Only LOAD writes RAM; the checksum byte in CHECK is consumed without a write
   assign wr_acc     = in_valid && (state == S_LOAD);
   assign last_acc   = wr_acc && (cnt == LAST);
   assign hold_end   = (hcnt == HW'(HOLD_CYCLES - 1));
   assign start_load = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum;
   logic              chk_acc;
   logic              sum_ok;

   assign chk_acc = in_valid && (state == S_CHECK);
   assign sum_ok  = ((sum + in_data) == '0);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sum <= '0;
      end else if (start_load) begin
         sum <= '0;
      end else if (wr_acc) begin
         sum <= sum + in_data;
      end
   end
`endif

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      cpu_hold = 1'b1;
      busy     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_load) state_nx = S_LOAD;
         end
         S_LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            if (last_acc) state_nx = S_CHECK;
`else
            if (last_acc) state_nx = S_RELEASE;
`endif
         end
         S_CHECK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
            in_ready = 1'b1;
            busy     = 1'b1;
            if (chk_acc) state_nx = sum_ok ? S_RELEASE : S_ERROR;
`else
            state_nx = S_IDLE;
`endif
         end
         S_RELEASE: begin
            busy = 1'b1;
            if (hold_end) state_nx = S_DONE;
         end
         S_DONE: begin
            cpu_hold = 1'b0;
            done     = 1'b1;
            if (start_load) state_nx = S_LOAD;
         end
         S_ERROR: begin
`ifdef PROG_LOADER_CHECKSUM_EN
            err = 1'b1;
`endif
            if (start_load) state_nx = S_LOAD;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Address counter saturates on the last byte so address 0 is never rewritten
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt      <= '0;
         hcnt     <= '0;
         ram_addr <= '0;
         ram_data <= '0;
         ram_we   <= 1'b0;
      end else begin
         ram_we <= wr_acc;
         if (wr_acc) begin
            ram_addr <= cnt;
            ram_data <= in_data;
            if (cnt != LAST) cnt <= cnt + 1'b1;
         end else if (start_load) begin
            cnt <= '0;
         end
         hcnt <= (state == S_RELEASE) ? hcnt + 1'b1 : '0;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader (PROG_LOADER_CHECKSUM_EN aware)
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       start = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] ram_addr;
   logic [7:0] ram_data;
   logic       ram_we;
   logic       cpu_hold;
   logic       busy;
   logic       done;
   logic       err;

   int checks = 0;
   int failures = 0;
   int wcount = 0;
   int run_len = 0;
   int max_run = 0;
   int wc0;
   logic [11:0] sbq[$];
   logic [3:0]  model_addr = 4'h0;
   logic [7:0]  model_sum = 8'h00;

   always #5 clk = ~clk;

   prog_loader dut (
      .clk(clk), .clr(clr), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every RAM write must match the next expected (addr,data)
   always @(negedge clk) begin : mon
      logic [11:0] e;
      if (ram_we === 1'b1) begin
         wcount++;
         run_len++;
         if (run_len > max_run) max_run = run_len;
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write addr=%0h data=%0h expected=no_write", ram_addr, ram_data);
         end else begin
            e = sbq.pop_front();
            check("wr_addr", ram_addr, e[11:8]);
            check("wr_data", ram_data, e[7:0]);
         end
      end else begin
         run_len = 0;
      end
   end

   task automatic do_start;
      start = 1'b1;
      tick;
      start = 1'b0;
      model_addr = 4'h0;
      model_sum = 8'h00;
   endtask

   task automatic send_bytes(input int n, input logic [7:0] base, input bit inc,
                             input bit gaps, input bit pulse);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data = inc ? base + 8'(i) : base;
         sbq.push_back({model_addr, in_data});
         model_addr++;
         model_sum += in_data;
         tick;
         if (gaps && (i < n - 1)) begin
            in_valid = 1'b0;
            start = pulse;
            tick;
            start = 1'b0;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic finish_load;
`ifdef PROG_LOADER_CHECKSUM_EN
      check("check_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data = 8'h00 - model_sum;
      tick;
`endif
      in_valid = 1'b1;
      in_data = 8'h55;
      check("rel_busy", busy, 1);
      check("rel_hold", cpu_hold, 1);
      check("rel_ready", in_ready, 0);
      check("rel_done", done, 0);
      tick;
      check("rel2_hold", cpu_hold, 1);
      check("rel2_done", done, 0);
      tick;
      check("done_hold", cpu_hold, 0);
      check("done_done", done, 1);
      check("done_busy", busy, 0);
      check("done_err", err, 0);
      tick;
      check("done_stays", done, 1);
      in_valid = 1'b0;
   endtask

   initial begin
      // 1: asynchronous reset mid-cycle
      #2 clr = 1'b1;
      #6 clr = 1'b0;
      check("rst_hold", cpu_hold, 1);
      check("rst_we", ram_we, 0);
      check("rst_ready", in_ready, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      tick;
      in_valid = 1'b1;
      in_data = 8'h77;
      tick;
      tick;
      in_valid = 1'b0;
      check("idle_no_write", wcount, 0);

      // 2: full back-to-back load, data == addr
      wc0 = wcount;
      max_run = 0;
      do_start;
      check("load_ready", in_ready, 1);
      check("load_busy", busy, 1);
      send_bytes(16, 8'h00, 1'b1, 1'b0, 1'b0);
      finish_load;
      check("t2_writes", wcount - wc0, 16);
      check("t2_consecutive", max_run, 16);

      // 3: stalled stream with ignored start pulses
      do_start;
      check("t3_hold_after_start", cpu_hold, 1);
      check("t3_done_after_start", done, 0);
      wc0 = wcount;
      max_run = 0;
      send_bytes(16, 8'h30, 1'b1, 1'b1, 1'b1);
      finish_load;
      check("t3_writes", wcount - wc0, 16);
      check("t3_gapped", max_run, 1);

      // 4: reset mid-load, then start with a simultaneous valid byte
      do_start;
      send_bytes(5, 8'h90, 1'b1, 1'b0, 1'b0);
      tick;
      check("t4_pending", sbq.size(), 0);
      clr = 1'b1;
      #3;
      check("t4_hold", cpu_hold, 1);
      check("t4_ready", in_ready, 0);
      check("t4_busy", busy, 0);
      check("t4_we", ram_we, 0);
      #2 clr = 1'b0;
      tick;
      in_valid = 1'b1;
      in_data = 8'hEE;
      do_start;
      send_bytes(16, 8'hC0, 1'b1, 1'b0, 1'b0);
      finish_load;

      // 5: reload from DONE overwrites 0..15
      do_start;
      check("t5_hold", cpu_hold, 1);
      check("t5_done", done, 0);
      check("t5_busy", busy, 1);
      send_bytes(16, 8'hA0, 1'b1, 1'b0, 1'b0);
      finish_load;

`ifdef PROG_LOADER_CHECKSUM_EN
      // 6: checksum pass and fail
      do_start;
      send_bytes(16, 8'h01, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      in_data = 8'hF0;
      tick;
      in_valid = 1'b0;
      tick;
      tick;
      check("t6_pass_done", done, 1);
      check("t6_pass_hold", cpu_hold, 0);
      do_start;
      send_bytes(16, 8'h01, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      in_data = 8'hF1;
      tick;
      in_valid = 1'b0;
      check("t6_err", err, 1);
      check("t6_err_hold", cpu_hold, 1);
      check("t6_err_done", done, 0);
      check("t6_err_busy", busy, 0);
      tick;
      tick;
      check("t6_err_sticky", err, 1);
      do_start;
      check("t6_restart_err", err, 0);
      check("t6_restart_busy", busy, 1);
      clr = 1'b1;
      #2 clr = 1'b0;
`else
      check("no_err", err, 0);
`endif

      tick;
      tick;
      check("scoreboard_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
